// File: rtl/pattern_stream_ctrl.sv
// Pattern stream controller: reads Num_Pat bursts of Words_Per_Pat words from a
// pattern FIFO. Optional inter-pattern idle gap enabled by defining PAT_GAP_EN.
module pattern_stream_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic        abort,
  input  logic [31:0] Num_Pat,
  input  logic [15:0] Words_Per_Pat,
  input  logic [7:0]  Gap_Len,
  input  logic [11:0] fifo_rd_count,
  input  logic        fifo_empty,
  output logic        stream_en,
  output logic        pat_load,
  output logic [31:0] pat_idx,
  output logic        busy,
  output logic        done,
  output logic        underflow
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    STREAM    = 3'd2,
`ifdef PAT_GAP_EN
    GAP       = 3'd3,
`endif
    DONE      = 3'd4
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] num_pat_q;
  logic [15:0] wpp_q;
  logic [15:0] word_cnt_q;
  logic [31:0] pat_idx_inc;
  logic        data_ready;
  logic        last_word;
  logic        trig_accept;

  logic        stream_en_d;
  logic        pat_load_d;
  logic        busy_d;
  logic        done_d;

`ifdef PAT_GAP_EN
  logic [7:0]  gap_len_q;
  logic [7:0]  gap_cnt_q;
`else
  logic        unused_gap_len;
  assign unused_gap_len = ^Gap_Len;
`endif

  // The FIFO count is compared against the sequence's captured burst length,
  // never the live port, so mid-sequence reprogramming cannot shorten a burst.
  assign data_ready  = ({4'd0, fifo_rd_count} >= wpp_q);
  assign last_word   = (state_q == STREAM) && (word_cnt_q == wpp_q - 16'd1);
  assign pat_idx_inc = pat_idx + 32'd1;
  assign trig_accept = (state_q == IDLE) && trig && !abort;

  // State register plus the registered copies of every output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      stream_en <= 1'b0;
      pat_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      stream_en <= stream_en_d;
      pat_load  <= pat_load_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: a default assignment at the top keeps this block free of latches on
    // paths that do not assign state_d explicitly.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          if ((Num_Pat == 32'd0) || (Words_Per_Pat == 16'd0)) state_d = DONE;
          else                                                state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_ready) state_d = STREAM;
      end
      STREAM: begin
        if (last_word) begin
          if (pat_idx_inc == num_pat_q) begin
            state_d = DONE;
          end else begin
`ifdef PAT_GAP_EN
            state_d = (gap_len_q != 8'd0) ? GAP : WAIT_DATA;
`else
            state_d = WAIT_DATA;
`endif
          end
        end
      end
`ifdef PAT_GAP_EN
      GAP: begin
        if (gap_cnt_q == gap_len_q - 8'd1) state_d = WAIT_DATA;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Output logic: values computed here become visible one edge later.
  always_comb begin
    stream_en_d = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    pat_load_d  = last_word && !abort;
  end

  // Sequence datapath: captured configuration, counters, progress and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_pat_q  <= 32'd0;
      wpp_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      pat_idx    <= 32'd0;
      underflow  <= 1'b0;
    end else begin
      if (trig_accept) begin
        num_pat_q <= Num_Pat;
        wpp_q     <= Words_Per_Pat;
      end

      if ((state_q == STREAM) && (state_d == STREAM)) word_cnt_q <= word_cnt_q + 16'd1;
      else                                             word_cnt_q <= 16'd0;

      if (trig_accept)     pat_idx <= 32'd0;
      else if (pat_load_d) pat_idx <= pat_idx_inc;

      // Sticky until the next accepted sequence start.
      if (trig_accept)                  underflow <= 1'b0;
      else if (stream_en && fifo_empty) underflow <= 1'b1;
    end
  end

`ifdef PAT_GAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_len_q <= 8'd0;
      gap_cnt_q <= 8'd0;
    end else begin
      if (trig_accept) gap_len_q <= Gap_Len;
      if ((state_q == GAP) && (state_d == GAP)) gap_cnt_q <= gap_cnt_q + 8'd1;
      else                                      gap_cnt_q <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Directed bench for pattern_stream_ctrl: a per-cycle vector table for a full
// three-pattern sequence plus hand-written multi-cycle corner sequences.
module tb_pattern_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset, trig, abort, fifo_empty;
  logic [31:0] Num_Pat;
  logic [15:0] Words_Per_Pat;
  logic [7:0]  Gap_Len;
  logic [11:0] fifo_rd_count;
  logic        stream_en, pat_load, busy, done, underflow;
  logic [31:0] pat_idx;

  int passed = 0;
  int total  = 0;
  int se_cnt, pl_cnt, done_cnt;

  pattern_stream_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .trig         (trig),
    .abort        (abort),
    .Num_Pat      (Num_Pat),
    .Words_Per_Pat(Words_Per_Pat),
    .Gap_Len      (Gap_Len),
    .fifo_rd_count(fifo_rd_count),
    .fifo_empty   (fifo_empty),
    .stream_en    (stream_en),
    .pat_load     (pat_load),
    .pat_idx      (pat_idx),
    .busy         (busy),
    .done         (done),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // exp packs {stream_en, pat_load, busy, done, underflow}
  typedef struct {
    logic        trig;
    logic [4:0]  exp;
    logic [31:0] idx;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    se_cnt   += int'(stream_en);
    pl_cnt   += int'(pat_load);
    done_cnt += int'(done);
  endtask

  task automatic clear_counts();
    se_cnt = 0; pl_cnt = 0; done_cnt = 0;
  endtask

  function automatic vec_t mk(input logic t, input logic [4:0] e, input logic [31:0] i);
    vec_t v;
    v.trig = t; v.exp = e; v.idx = i;
    return v;
  endfunction

  initial begin
    int phase, gap_low, exp_gap;

    // Three patterns of four words, data always available; trig while busy ignored.
    vecs[0]  = mk(1, 5'b00100, 0);
    vecs[1]  = mk(0, 5'b10100, 0);
    vecs[2]  = mk(0, 5'b10100, 0);
    vecs[3]  = mk(1, 5'b10100, 0);
    vecs[4]  = mk(0, 5'b10100, 0);
    vecs[5]  = mk(0, 5'b01100, 1);
    vecs[6]  = mk(0, 5'b10100, 1);
    vecs[7]  = mk(1, 5'b10100, 1);
    vecs[8]  = mk(0, 5'b10100, 1);
    vecs[9]  = mk(0, 5'b10100, 1);
    vecs[10] = mk(0, 5'b01100, 2);
    vecs[11] = mk(0, 5'b10100, 2);
    vecs[12] = mk(0, 5'b10100, 2);
    vecs[13] = mk(0, 5'b10100, 2);
    vecs[14] = mk(0, 5'b10100, 2);
    vecs[15] = mk(0, 5'b01110, 3);
    vecs[16] = mk(0, 5'b00000, 3);
    vecs[17] = mk(0, 5'b00000, 3);

    reset = 1'b1; trig = 1'b1; abort = 1'b1; fifo_empty = 1'b0;
    Num_Pat = 32'd3; Words_Per_Pat = 16'd4; Gap_Len = 8'd0; fifo_rd_count = 12'd100;
    clear_counts();

    // Reset dominates trig and abort
    tick(); tick();
    check("reset_outputs", {stream_en, pat_load, busy, done, underflow, pat_idx},
          {5'b00000, 32'd0});
    reset = 1'b0; trig = 1'b0; abort = 1'b0;
    tick();

    // Table-driven full sequence
    clear_counts();
    for (int i = 0; i < 18; i++) begin
      trig = vecs[i].trig;
      tick();
      check($sformatf("vec%0d", i),
            {stream_en, pat_load, busy, done, underflow, pat_idx},
            {vecs[i].exp, vecs[i].idx});
    end
    trig = 1'b0;
    check("seq_stream_total", se_cnt, 12);
    check("seq_done_total", done_cnt, 1);

    // Waiting for data; config changes after capture must be ignored
    Num_Pat = 32'd1; Words_Per_Pat = 16'd8; fifo_rd_count = 12'd5;
    trig = 1'b1; tick(); trig = 1'b0;
    Words_Per_Pat = 16'd2; Num_Pat = 32'd5;
    clear_counts();
    for (int i = 0; i < 20; i++) tick();
    check("wait_no_stream", se_cnt, 0);
    check("wait_busy", busy, 1);
    fifo_rd_count = 12'd8;
    clear_counts();
    tick();
    check("wait_first_word", stream_en, 1);
    for (int i = 0; i < 11; i++) tick();
    check("wait_burst_len", se_cnt, 8);
    check("wait_pl_done", {pl_cnt[7:0], done_cnt[7:0], busy}, {8'd1, 8'd1, 1'b0});
    check("wait_pat_idx", pat_idx, 1);
    fifo_rd_count = 12'd100;

    // Underflow on the 2nd word, sticky through done, cleared by the next trig
    Num_Pat = 32'd1; Words_Per_Pat = 16'd4;
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    check("uf_before", {stream_en, underflow}, 2'b10);
    fifo_empty = 1'b1; tick(); fifo_empty = 1'b0;
    check("uf_set", underflow, 1);
    tick(); tick();
    check("uf_at_done", {done, underflow}, 2'b11);
    tick();
    check("uf_sticky_idle", {busy, underflow}, 2'b01);
    trig = 1'b1; tick(); trig = 1'b0;
    check("uf_cleared", {busy, underflow}, 2'b10);
    for (int i = 0; i < 8; i++) tick();
    check("uf_seq_end", {busy, underflow}, 2'b00);

    // Abort on the 3rd stream_en cycle of pattern 1
    Num_Pat = 32'd2; Words_Per_Pat = 16'd4;
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick(); tick();
    check("abort_pre", stream_en, 1);
    abort = 1'b1;
    clear_counts();
    tick(); abort = 1'b0;
    check("abort_next", {stream_en, busy, pat_load, done}, 4'b0000);
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_pulses", {pl_cnt[7:0], done_cnt[7:0], se_cnt[7:0]}, 24'd0);
    check("abort_pat_idx", pat_idx, 0);
    abort = 1'b1; trig = 1'b1; tick(); abort = 1'b0; trig = 1'b0;
    check("abort_over_trig", busy, 0);

    // Zero-length sequences
    clear_counts();
    Num_Pat = 32'd0; Words_Per_Pat = 16'd4;
    trig = 1'b1; tick(); trig = 1'b0;
    check("zero_pat_done", {stream_en, busy, done}, 3'b011);
    tick();
    check("zero_pat_idle", {busy, done}, 2'b00);
    Num_Pat = 32'd2; Words_Per_Pat = 16'd0;
    trig = 1'b1; tick();
    check("zero_wpp_done", {stream_en, busy, done}, 3'b011);
    tick(); trig = 1'b0;
    check("zero_wpp_idle", {busy, done}, 2'b00);
    check("zero_no_stream", se_cnt, 0);

    // Spacing between bursts with a nonzero Gap_Len
`ifdef PAT_GAP_EN
    exp_gap = 4;
`else
    exp_gap = 1;
`endif
    Num_Pat = 32'd2; Words_Per_Pat = 16'd2; Gap_Len = 8'd3;
    clear_counts();
    phase = 0; gap_low = 0;
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      case (phase)
        0: if (stream_en) phase = 1;
        1: if (!stream_en) begin phase = 2; gap_low = 1; end
        2: if (stream_en) phase = 3; else gap_low++;
        default: ;
      endcase
    end
    check("gap_low_cycles", gap_low, exp_gap);
    check("gap_bursts", {phase[7:0], se_cnt[7:0], busy}, {8'd3, 8'd4, 1'b0});
    Gap_Len = 8'd0;

    // Reset in mid-stream
    Num_Pat = 32'd3; Words_Per_Pat = 16'd4;
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_mid_stream", {stream_en, busy, pat_idx}, {2'b00, 32'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
